fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 104 ++++++++++
 tb/tb_fetch_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit -- instruction fetch stage feeding the IF/ID pipeline register.
//
// The PC register addresses a combinational instruction memory.  Each RUN
// edge registers the returned word together with PC+4 into the IF/ID
// outputs.  A zero word (unmapped memory) can halt fetch when HALT_ON_ZERO
// is set; only a branch redirect or reset resumes fetching.
//
// Parameters
//   RESET_PC      PC value loaded on reset
//   HALT_ON_ZERO  1: a fetched word of 0 halts fetch
//
// Ports
//   clk           single clock, rising edge
//   rst           asynchronous active-high reset
//   freeze        downstream hazard stall: hold PC and IF/ID outputs
//   branch_taken  redirect request from execute (wins over freeze)
//   branch_addr   byte address of the redirect target
//   imem_addr     word-aligned byte address to instruction memory
//   imem_instr    combinational instruction word for imem_addr
//   pc_out        registered fetched PC + 4
//   instr_out     registered fetched instruction
//   valid_out     pc_out/instr_out hold a live instruction
//   halted        fetch FSM is in HALTED
//   fetch_count   saturating count of instructions issued with valid_out=1
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC     = 32'd0,
  parameter bit          HALT_ON_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [31:0] pc_out,
  output logic [31:0] instr_out,
  output logic        valid_out,
  output logic        halted,
  output logic [15:0] fetch_count
);

  localparam logic [0:0] S_RUN    = 1'b0;
  localparam logic [0:0] S_HALTED = 1'b1;

  logic [0:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_pc_out;
  logic [31:0] r_instr;
  logic        r_valid;
  logic [15:0] r_count;

  logic [31:0] w_pc_plus4;
  logic        w_zero_halt;

  // Natural 32-bit wrap: 0xFFFFFFFC + 4 = 0.
  assign w_pc_plus4  = r_pc + 32'd4;
  assign w_zero_halt = HALT_ON_ZERO && (imem_instr == 32'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_RUN;
      r_pc     <= RESET_PC;
      r_pc_out <= 32'd0;
      r_instr  <= 32'd0;
      r_valid  <= 1'b0;
      r_count  <= 16'd0;
    end else if (branch_taken) begin
      // Redirect flushes the IF/ID slot and leaves any halt.
      r_state  <= S_RUN;
      r_pc     <= branch_addr & 32'hFFFF_FFFC;
      r_pc_out <= 32'd0;
      r_instr  <= 32'd0;
      r_valid  <= 1'b0;
    end else if (freeze) begin
      // Hold everything, including the issue counter.
    end else if (r_state == S_HALTED) begin
      r_valid <= 1'b0;
    end else if (w_zero_halt) begin
      // Halt on the same edge the zero word is seen; PC stays on it.
      r_instr <= 32'd0;
      r_valid <= 1'b0;
      r_state <= S_HALTED;
    end else begin
      r_pc     <= w_pc_plus4;
      r_pc_out <= w_pc_plus4;
      r_instr  <= imem_instr;
      r_valid  <= 1'b1;
      if (r_count != 16'hFFFF) begin
        r_count <= r_count + 16'd1;
      end
    end
  end

  assign imem_addr   = r_pc & 32'hFFFF_FFFC;
  assign pc_out      = r_pc_out;
  assign instr_out   = r_instr;
  assign valid_out   = r_valid;
  assign halted      = (r_state == S_HALTED);
  assign fetch_count = r_count;

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit -- directed bench for fetch_unit with an attached program ROM.
// Expected IF/ID transactions are queued when an issuing edge is set up and
// popped when the DUT presents them; status outputs are checked every cycle
// against a small reference model, plus fixed constants at key points.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] pc_out;
  logic [31:0] instr_out;
  logic        valid_out;
  logic        halted;
  logic [15:0] fetch_count;

  fetch_unit #(.RESET_PC(32'd0), .HALT_ON_ZERO(1'b1)) dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem_addr    (imem_addr),
    .imem_instr   (imem_instr),
    .pc_out       (pc_out),
    .instr_out    (instr_out),
    .valid_out    (valid_out),
    .halted       (halted),
    .fetch_count  (fetch_count)
  );

  // Program ROM: mapped words below 156, one mapped word at the top of memory.
  function automatic logic [31:0] rom(input logic [31:0] a);
    if (a == 32'hFFFF_FFFC) return 32'hA5A5_0001;
    if (a == 32'd0)         return 32'hE3A0_0014;
    if (a < 32'd156)        return 32'hE280_0000 | a;
    return 32'd0;
  endfunction

  assign imem_instr = rom(imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } txn_t;

  txn_t        sb_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_pcout;
  logic [31:0] m_instr;
  logic        m_valid;
  logic        m_halt;
  logic [15:0] m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'd0; m_pcout = 32'd0; m_instr = 32'd0;
    m_valid = 1'b0; m_halt = 1'b0; m_cnt = 16'd0;
    sb_q.delete();
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".imem_addr"},   imem_addr,          m_pc);
    chk({tag, ".valid_out"},   {31'd0, valid_out}, {31'd0, m_valid});
    chk({tag, ".halted"},      {31'd0, halted},    {31'd0, m_halt});
    chk({tag, ".fetch_count"}, {16'd0, fetch_count}, {16'd0, m_cnt});
    chk({tag, ".pc_out"},      pc_out,             m_pcout);
    chk({tag, ".instr_out"},   instr_out,          m_instr);
  endtask

  // One clock: predict from current inputs, clock, then compare.
  task automatic cycle(input string tag);
    logic [31:0] w;
    logic        issued;
    txn_t        t;
    issued = 1'b0;
    w = rom(m_pc);
    if (branch_taken) begin
      m_pc = branch_addr & 32'hFFFF_FFFC;
      m_pcout = 32'd0; m_instr = 32'd0; m_valid = 1'b0; m_halt = 1'b0;
    end else if (freeze) begin
    end else if (m_halt) begin
      m_valid = 1'b0;
    end else if (w != 32'd0) begin
      t.pc = m_pc + 32'd4;
      t.instr = w;
      sb_q.push_back(t);
      issued = 1'b1;
      m_pc = m_pc + 32'd4;
      m_pcout = m_pc; m_instr = w; m_valid = 1'b1;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end else begin
      m_instr = 32'd0; m_valid = 1'b0; m_halt = 1'b1;
    end
    @(posedge clk);
    #1;
    if (issued) begin
      t = sb_q.pop_front();
      chk({tag, ".sb_pc"},    pc_out,    t.pc);
      chk({tag, ".sb_instr"}, instr_out, t.instr);
      $display("txn %s: pc_out=%h instr_out=%h valid=%0b count=%0d",
               tag, pc_out, instr_out, valid_out, fetch_count);
    end else begin
      $display("cyc %s: imem_addr=%h valid=%0b halted=%0b count=%0d",
               tag, imem_addr, valid_out, halted, fetch_count);
    end
    chk_state(tag);
  endtask

  initial begin
    rst = 1'b0; freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'd0;
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk_state("reset");
    @(posedge clk); #1;
    chk_state("reset_hold");
    #2 rst = 1'b0;   // release between edges
    @(negedge clk);

    // Free-run from RESET_PC
    cycle("run1");
    chk("run1.pc_const",    pc_out,    32'd4);
    chk("run1.instr_const", instr_out, 32'hE3A0_0014);
    cycle("run2");
    cycle("run3");
    chk("run3.pc_const",    pc_out,                32'd12);
    chk("run3.count_const", {16'd0, fetch_count},  32'd3);

    // Freeze two cycles at imem_addr=12
    freeze = 1'b1;
    cycle("frz1");
    chk("frz1.addr_const", imem_addr, 32'd12);
    cycle("frz2");
    chk("frz2.pc_const",   pc_out,    32'd12);
    freeze = 1'b0;
    cycle("unfrz");
    chk("unfrz.pc_const",    pc_out,               32'd16);
    chk("unfrz.count_const", {16'd0, fetch_count}, 32'd4);

    // Branch during freeze to an unaligned target
    freeze = 1'b1; branch_taken = 1'b1; branch_addr = 32'h73;
    cycle("brfrz");
    chk("brfrz.addr_const", imem_addr, 32'h70);
    branch_taken = 1'b0; freeze = 1'b0;
    cycle("brnext");
    chk("brnext.pc_const", pc_out, 32'h74);

    // Run into unmapped memory at 156
    for (int i = 0; i < 40 && !m_halt; i++) cycle("tohalt");
    chk("halt.reached", {31'd0, halted}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      cycle("halted");
      chk("halted.addr_const", imem_addr, 32'd156);
    end

    // Leave HALTED by branch
    branch_taken = 1'b1; branch_addr = 32'd112;
    cycle("unhalt");
    branch_taken = 1'b0;
    cycle("unhalt_run");
    chk("unhalt_run.pc_const", pc_out, 32'd116);

    // Wrap at the top of the address space
    branch_taken = 1'b1; branch_addr = 32'hFFFF_FFFC;
    cycle("br_top");
    branch_taken = 1'b0;
    cycle("wrap");
    chk("wrap.pc_const",   pc_out,    32'd0);
    chk("wrap.addr_const", imem_addr, 32'd0);

    // Reach HALTED with fetch_count=9, then async reset between edges
    #2 rst = 1'b1;
    model_reset();
    #1 rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 9; i++) cycle("cnt9");
    branch_taken = 1'b1; branch_addr = 32'd156;
    cycle("br156");
    branch_taken = 1'b0;
    cycle("halt9");
    chk("halt9.count_const", {16'd0, fetch_count}, 32'd9);
    chk("halt9.halted",      {31'd0, halted},      32'd1);
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk_state("async_rst");
    chk("async_rst.count_const", {16'd0, fetch_count}, 32'd0);
    #1 rst = 1'b0;
    cycle("post_rst");
    chk("post_rst.pc_const", pc_out, 32'd4);

    chk("sb.empty", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
